// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between instruction fetch
//   and the memory stage. Requests are arbitrated one transaction at a time with
//   round-robin priority. The losing requester stays stalled. Read data comes
//   back with a one-cycle valid pulse. A transaction that receives no MemAck
//   within TIMEOUT busy cycles is aborted and the sticky BusErr flag is set.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   InstrReq/InstrAddr/FlushF        fetch request, fetch address, fetch discard
//   DataReq/DataWe/DataAddr/DataWData  load/store request from the memory stage
//   MemAck/MemRData                  memory completion strobe and read data
//   MemReq/MemWe/MemAddr/MemWData    registered transaction presented to memory
//   InstrValid/InstrRData            one-cycle fetch completion and fetched word
//   DataValid/DataRData              one-cycle load/store completion and load data
//   StallIF/StallMem                 combinational pipeline stall requests
//   BusErr                           sticky timeout flag, cleared only by reset
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          InstrReq,
  input  logic [AW-1:0] InstrAddr,
  input  logic          FlushF,
  input  logic          DataReq,
  input  logic          DataWe,
  input  logic [AW-1:0] DataAddr,
  input  logic [DW-1:0] DataWData,
  input  logic          MemAck,
  input  logic [DW-1:0] MemRData,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic          InstrValid,
  output logic [DW-1:0] InstrRData,
  output logic          DataValid,
  output logic [DW-1:0] DataRData,
  output logic          StallIF,
  output logic          StallMem,
  output logic          BusErr
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, INSTR, DATA} arbStateT;

  arbStateT      state;
  arbStateT      stateNext;
  logic          lastData;     // 1: data port was served most recently
  logic          discard;      // in-flight fetch result must be dropped
  logic [CW-1:0] timeoutCnt;

  logic instrElig;
  logic dataElig;
  logic busy;
  logic ackDone;
  logic expired;
  logic done;
  logic grantInstr;
  logic grantData;

  // A port whose Valid is high this cycle still shows its old request, so it
  // must not be granted again until the following cycle.
  always_comb begin
    instrElig  = InstrReq & ~InstrValid;
    dataElig   = DataReq & ~DataValid;
    busy       = (state != IDLE);
    ackDone    = busy & MemAck;
    expired    = busy & ~MemAck & (timeoutCnt == CW'(TIMEOUT - 1));
    done       = ackDone | expired;
    grantData  = (state == IDLE) & dataElig & (~instrElig | ~lastData);
    grantInstr = (state == IDLE) & instrElig & ~grantData;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (grantData) begin
          stateNext = DATA;
        end else if (grantInstr) begin
          stateNext = INSTR;
        end
      end
      INSTR, DATA: begin
        if (done) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    StallIF  = InstrReq & ~InstrValid;
    StallMem = DataReq & ~DataValid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Transaction launch: memory-side outputs are captured at grant and held
  // until completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      lastData <= 1'b0;
    end else if (grantData) begin
      MemReq   <= 1'b1;
      MemWe    <= DataWe;
      MemAddr  <= DataAddr;
      MemWData <= DataWData;
      lastData <= 1'b1;
    end else if (grantInstr) begin
      MemReq   <= 1'b1;
      MemWe    <= 1'b0;
      MemAddr  <= InstrAddr;
      MemWData <= '0;
      lastData <= 1'b0;
    end else if (done) begin
      MemReq <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutCnt <= '0;
    end else if (grantData || grantInstr || done) begin
      timeoutCnt <= '0;
    end else if (busy) begin
      timeoutCnt <= timeoutCnt + CW'(1);
    end
  end

  // A flush in the ack cycle also kills the result, hence FlushF is folded
  // into the InstrValid decision as well as into the discard flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= 1'b0;
    end else if (grantInstr) begin
      discard <= FlushF;
    end else if (done) begin
      discard <= 1'b0;
    end else if ((state == INSTR) && FlushF) begin
      discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrValid <= 1'b0;
      InstrRData <= '0;
      DataValid  <= 1'b0;
      DataRData  <= '0;
    end else begin
      InstrValid <= 1'b0;
      DataValid  <= 1'b0;
      if (done && (state == INSTR) && !discard && !FlushF) begin
        InstrValid <= 1'b1;
        InstrRData <= ackDone ? MemRData : '0;
      end
      if (done && (state == DATA)) begin
        DataValid <= 1'b1;
        DataRData <= (ackDone && !MemWe) ? MemRData : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BusErr <= 1'b0;
    end else if (expired) begin
      BusErr <= 1'b1;
    end
  end

endmodule
